enc_cnt_capture_fifo: RTL and testbench

Downstream capture stage for one ENC_TOP counter channel, instantiated once per channel. On each new A-edge strobe from the encoder counter (O_A0/O_A1) while armed, it snapshots the 64-bit count and overflow flag into a first-word-fall-through FIFO. It also tags each entry with a sequence number. Entries are drained by the readout/DMA logic over a valid/ready handshake.

---
 rtl/enc_cnt_capture_fifo.sv | 131 +++++++++++++
 tb/tb_enc_cnt_capture_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc_cnt_capture_fifo.sv
// Capture FIFO for one encoder counter channel: snapshots count/overflow/seq on strobe edges.
// Optional build macro CAP_TIMESTAMP_EN adds a free-running timestamp stored with each entry.
module enc_cnt_capture_fifo #(
  parameter int P_DEPTH = 16,
  parameter int P_CNT_W = 64,
  parameter int P_SEQ_W = 16,
  parameter int P_TS_W  = 32
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       I_ARM,
  input  logic                       I_STB,
  input  logic [P_CNT_W-1:0]         I_CNT,
  input  logic                       I_OVF,
  input  logic                       I_CNT_READY,
  output logic                       O_RD_VALID,
  input  logic                       I_RD_READY,
  output logic [P_CNT_W-1:0]         O_RD_CNT,
  output logic                       O_RD_OVF,
  output logic [P_SEQ_W-1:0]         O_RD_SEQ,
  output logic [P_TS_W-1:0]          O_RD_TS,
  output logic [$clog2(P_DEPTH):0]   O_LEVEL,
  output logic                       O_FULL,
  output logic [15:0]                O_DROP_CNT,
  output logic [1:0]                 O_STATE
);
  localparam int AW = $clog2(P_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(P_DEPTH);

  typedef struct packed {
    logic [P_CNT_W-1:0] cnt;
    logic               ovf;
    logic [P_SEQ_W-1:0] seq;
`ifdef CAP_TIMESTAMP_EN
    logic [P_TS_W-1:0]  ts;
`endif
  } entry_t;

  entry_t              mem [P_DEPTH];
  entry_t              wdata, head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         level;
  logic [P_SEQ_W-1:0]  seq;
  logic [15:0]         drop_cnt;
  logic [1:0]          state, state_nxt;
  logic                stb_q, arm_q;
  logic                cap_evt, arm_rise, qual, empty, full, pop, push, drop;

  assign cap_evt  = I_STB & ~stb_q;
  assign arm_rise = I_ARM & ~arm_q;
  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign qual     = (state == S_ARMED) & I_ARM & I_CNT_READY & cap_evt;
  assign pop      = ~empty & I_RD_READY;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign push     = qual & (~full | pop);
  assign drop     = qual & full & ~pop;

`ifdef CAP_TIMESTAMP_EN
  logic [P_TS_W-1:0] ts;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        ts <= '0;
    else if (arm_rise) ts <= '0;
    else               ts <= ts + 1'b1;
  end
  assign wdata   = '{cnt: I_CNT, ovf: I_OVF, seq: seq, ts: ts};
  assign O_RD_TS = O_RD_VALID ? head.ts : '0;
`else
  assign wdata   = '{cnt: I_CNT, ovf: I_OVF, seq: seq};
  assign O_RD_TS = '0;
`endif

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head       = mem[rd_ptr];
  assign O_RD_VALID = ~empty;
  assign O_RD_CNT   = O_RD_VALID ? head.cnt : '0;
  assign O_RD_OVF   = O_RD_VALID & head.ovf;
  assign O_RD_SEQ   = O_RD_VALID ? head.seq : '0;
  assign O_LEVEL    = level;
  assign O_FULL     = full;
  assign O_DROP_CNT = drop_cnt;
  assign O_STATE    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm_rise) state_nxt = S_ARMED;
      S_ARMED: if (!I_ARM)   state_nxt = empty ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (arm_rise)   state_nxt = S_ARMED;
        else if (empty) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      stb_q    <= 1'b0;
      arm_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      stb_q <= I_STB;
      arm_q <= I_ARM;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Dropped captures still consume a tag so gaps show up downstream.
      if (arm_rise)  seq <= '0;
      else if (qual) seq <= seq + 1'b1;
      if (arm_rise)                           drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_enc_cnt_capture_fifo.sv
// Scoreboard bench for enc_cnt_capture_fifo: expected entries queued at stimulus, checked at pop.
module tb_enc_cnt_capture_fifo;
  localparam int DEPTH = 16;

  logic        CLK = 0, RST_N = 0;
  logic        I_ARM = 0, I_STB = 0, I_OVF = 0, I_CNT_READY = 0, I_RD_READY = 0;
  logic [63:0] I_CNT = '0;
  logic        O_RD_VALID, O_RD_OVF, O_FULL;
  logic [63:0] O_RD_CNT;
  logic [15:0] O_RD_SEQ, O_DROP_CNT;
  logic [31:0] O_RD_TS;
  logic [4:0]  O_LEVEL;
  logic [1:0]  O_STATE;

  enc_cnt_capture_fifo #(.P_DEPTH(DEPTH), .P_CNT_W(64), .P_SEQ_W(16), .P_TS_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .I_ARM(I_ARM), .I_STB(I_STB), .I_CNT(I_CNT), .I_OVF(I_OVF),
    .I_CNT_READY(I_CNT_READY), .O_RD_VALID(O_RD_VALID), .I_RD_READY(I_RD_READY),
    .O_RD_CNT(O_RD_CNT), .O_RD_OVF(O_RD_OVF), .O_RD_SEQ(O_RD_SEQ), .O_RD_TS(O_RD_TS),
    .O_LEVEL(O_LEVEL), .O_FULL(O_FULL), .O_DROP_CNT(O_DROP_CNT), .O_STATE(O_STATE));

  always #5 CLK = ~CLK;

  typedef struct { logic [63:0] cnt; logic ovf; logic [15:0] seq; } exp_t;
  exp_t sb[$];
  int   n_checks = 0, n_err = 0;
  logic        m_armed = 0;
  logic [15:0] m_seq = 0, m_drop = 0;
  logic [31:0] last_ts;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model a qualified capture; only called when no pop coincides.
  task automatic model_cap(input logic [63:0] cnt, input logic ovf, input logic rdy);
    exp_t e;
    if (m_armed && rdy) begin
      if (sb.size() < DEPTH) begin
        e.cnt = cnt; e.ovf = ovf; e.seq = m_seq;
        sb.push_back(e);
      end else if (m_drop != 16'hFFFF) m_drop++;
      m_seq++;
    end
  endtask

  task automatic capture(input logic [63:0] cnt, input logic ovf, input logic rdy);
    I_CNT = cnt; I_OVF = ovf; I_CNT_READY = rdy; I_STB = 1;
    model_cap(cnt, ovf, rdy);
    tick();
    I_STB = 0;
    tick();
  endtask

  task automatic pop_one(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL %s: scoreboard empty on pop", name);
      return;
    end
    e = sb.pop_front();
    if (O_RD_VALID !== 1'b1) begin
      n_checks++; n_err++;
      $display("FAIL %s_valid: got %b expected 1", name, O_RD_VALID);
    end else begin
      if (O_RD_CNT !== e.cnt || O_RD_OVF !== e.ovf || O_RD_SEQ !== e.seq) begin
        n_err++;
        $display("FAIL %s: got cnt=%0d ovf=%b seq=%0d expected cnt=%0d ovf=%b seq=%0d",
                 name, O_RD_CNT, O_RD_OVF, O_RD_SEQ, e.cnt, e.ovf, e.seq);
      end
      n_checks++;
`ifndef CAP_TIMESTAMP_EN
      chk({name, "_ts0"}, 64'(O_RD_TS), 64'd0);
`endif
      last_ts = O_RD_TS;
    end
    I_RD_READY = 1;
    tick();
    I_RD_READY = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) pop_one(name);
    chk({name, "_empty"}, 64'(O_RD_VALID), 64'd0);
  endtask

  task automatic arm();
    I_ARM = 1; m_armed = 1; m_seq = 0; m_drop = 0;
    tick();
    chk("arm_state", 64'(O_STATE), 64'd1);
    chk("arm_drop_clr", 64'(O_DROP_CNT), 64'd0);
  endtask

  task automatic disarm();
    I_ARM = 0; m_armed = 0;
    tick();
  endtask

  task automatic test_reset();
    RST_N = 0;
    #12;
    chk("rst_valid", 64'(O_RD_VALID), 64'd0);
    chk("rst_level", 64'(O_LEVEL), 64'd0);
    chk("rst_full", 64'(O_FULL), 64'd0);
    chk("rst_drop", 64'(O_DROP_CNT), 64'd0);
    chk("rst_state", 64'(O_STATE), 64'd0);
    chk("rst_cnt", O_RD_CNT, 64'd0);
    @(negedge CLK); RST_N = 1;
    tick();
  endtask

  task automatic test_basic();
    arm();
    capture(64'd10, 1'b0, 1'b1);
    capture(64'd20, 1'b1, 1'b1);
    capture(64'd30, 1'b0, 1'b1);
    chk("basic_level", 64'(O_LEVEL), 64'd3);
    drain("basic");
  endtask

  task automatic test_strobe_width();
    exp_t e;
    I_CNT = 64'd77; I_OVF = 0; I_CNT_READY = 1; I_STB = 1;
    e.cnt = 64'd77; e.ovf = 0; e.seq = m_seq; sb.push_back(e); m_seq++;
    repeat (5) tick();
    I_STB = 0;
    tick();
    chk("wide_level", 64'(O_LEVEL), 64'd1);
    capture(64'd88, 1'b0, 1'b0);
    chk("notready_level", 64'(O_LEVEL), 64'd1);
    chk("notready_drop", 64'(O_DROP_CNT), 64'd0);
    drain("wide");
  endtask

  task automatic test_overflow();
    exp_t e;
    disarm();
    arm();
    for (int i = 0; i < 18; i++) capture(64'(100 + i), 1'(i % 3 == 0), 1'b1);
    chk("ovf_full", 64'(O_FULL), 64'd1);
    chk("ovf_level", 64'(O_LEVEL), 64'd16);
    chk("ovf_drop", 64'(O_DROP_CNT), 64'(m_drop));
    chk("ovf_drop2", 64'(O_DROP_CNT), 64'd2);
    chk("ovf_head_seq", 64'(O_RD_SEQ), 64'd0);
    // full with capture and pop in the same cycle
    e = sb.pop_front();
    chk("fullpop_head", 64'(O_RD_SEQ), 64'(e.seq));
    I_CNT = 64'd999; I_OVF = 1; I_STB = 1; I_RD_READY = 1;
    e.cnt = 64'd999; e.ovf = 1; e.seq = m_seq; sb.push_back(e); m_seq++;
    tick();
    I_STB = 0; I_RD_READY = 0;
    tick();
    chk("fullpop_level", 64'(O_LEVEL), 64'd16);
    chk("fullpop_drop", 64'(O_DROP_CNT), 64'd2);
    chk("fullpop_seq18", 64'(sb[$].seq), 64'd18);
    drain("ovf");
  endtask

  task automatic test_disarm();
    for (int i = 0; i < 4; i++) capture(64'(500 + i), 1'b0, 1'b1);
    disarm();
    chk("disarm_state", 64'(O_STATE), 64'd2);
    capture(64'd1234, 1'b0, 1'b1);
    chk("disarm_ignored", 64'(O_LEVEL), 64'd4);
    chk("disarm_drop_kept", 64'(O_DROP_CNT), 64'd2);
    for (int i = 0; i < 4; i++) pop_one("disarm");
    tick();
    chk("disarm_idle", 64'(O_STATE), 64'd0);
    arm();
    capture(64'd42, 1'b0, 1'b1);
    drain("rearm");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) capture(64'(700 + i), 1'b0, 1'b1);
    chk("pre_rst_level", 64'(O_LEVEL), 64'd5);
    #2 RST_N = 0;
    #1;
    chk("arst_valid", 64'(O_RD_VALID), 64'd0);
    chk("arst_level", 64'(O_LEVEL), 64'd0);
    chk("arst_state", 64'(O_STATE), 64'd0);
    sb.delete();
    I_ARM = 0; m_armed = 0;
    @(negedge CLK); RST_N = 1;
    tick();
  endtask

  task automatic test_timestamp();
`ifdef CAP_TIMESTAMP_EN
    logic [31:0] t0;
    arm();
    capture(64'd1, 1'b0, 1'b1);
    repeat (5) tick();
    capture(64'd2, 1'b0, 1'b1);
    pop_one("ts_a");
    t0 = last_ts;
    pop_one("ts_b");
    chk("ts_diff", 64'(last_ts - t0), 64'd7);
    disarm();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe_width();
    test_overflow();
    test_disarm();
    test_async_reset();
    test_timestamp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
